fsm_seq_gen: RTL and testbench

- Serial bit-pattern transmitter. It is the stimulus/driving end for the team's serial sequence detectors.
- It captures a parallel pattern of programmable length and shifts it out MSB-first, one bit per clock.
- The pattern repeats a programmable number of passes, with a fixed idle gap between passes.
- It handshakes with a controller through start_i/ready_o and signals completion with a done_o pulse.

---
 rtl/fsm_seq_gen_if.sv | 28 ++
 rtl/fsm_seq_gen.sv | 164 ++++++++++++++++
 tb/tb_fsm_seq_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_seq_gen_if.sv
// Handshake and serial-output bundle between a controller and fsm_seq_gen.
// The controller drives the master side and the generator is the slave.
interface fsm_seq_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start_i;
  logic             abort_i;
  logic [PAT_W-1:0] pattern_i;
  logic [LEN_W-1:0] len_i;
  logic [CNT_W-1:0] reps_i;
  logic             ready_o;
  logic             data_o;
  logic             valid_o;
  logic             last_o;
  logic             done_o;

  modport master (
    output start_i, abort_i, pattern_i, len_i, reps_i,
    input  ready_o, data_o, valid_o, last_o, done_o
  );

  modport slave (
    input  start_i, abort_i, pattern_i, len_i, reps_i,
    output ready_o, data_o, valid_o, last_o, done_o
  );
endinterface

// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first for reps+1 passes
// separated by GAP idle cycles. Define FSM_SEQ_GEN_PARITY_EN to append an even-parity bit per pass.
module fsm_seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input logic          clk_i,
  input logic          reset_i,
  fsm_seq_gen_if.slave bus
);

`ifdef FSM_SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // One extra index bit so len+PAR never overflows the bit index.
  localparam int IW       = LEN_W + 1;
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
  } cfg_t;

  state_t           state_q, state_n;
  cfg_t             cfg_q, cfg_n;
  logic [IW-1:0]    idx_q, idx_n;
  logic [CNT_W-1:0] pass_q, pass_n;
  logic [GW-1:0]    gap_q, gap_n;

  logic ready_q, data_q, valid_q, last_q, done_q;
  logic ready_n, data_n, valid_n, last_n, done_n;

  logic [LEN_W-1:0] len_clamp;
  logic [IW-1:0]    last_idx_q, last_idx_n, sel_n;
  logic             bit_n, par_n;

  assign len_clamp  = (bus.len_i > PAT_MAX) ? PAT_MAX : bus.len_i;
  assign last_idx_q = IW'(cfg_q.len) + IW'(PAR) - IW'(1);

  always_comb begin
    state_n = state_q;
    cfg_n   = cfg_q;
    idx_n   = idx_q;
    pass_n  = pass_q;
    gap_n   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i && (bus.len_i != '0)) begin
          cfg_n.pat = bus.pattern_i;
          cfg_n.len = len_clamp;
          pass_n    = bus.reps_i;
          idx_n     = '0;
          gap_n     = '0;
          state_n   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.abort_i) begin
          state_n = S_IDLE;
          idx_n   = '0;
          pass_n  = '0;
          gap_n   = '0;
        end else if (idx_q == last_idx_q) begin
          idx_n = '0;
          if (pass_q == '0) begin
            state_n = S_DONE;
          end else begin
            // Counting down from reps lets all-ones give 2^CNT_W passes with no wrap.
            pass_n = pass_q - CNT_W'(1);
            if (GAP > 0) begin
              state_n = S_GAP;
              gap_n   = '0;
            end
          end
        end else begin
          idx_n = idx_q + IW'(1);
        end
      end
      S_GAP: begin
        if (bus.abort_i) begin
          state_n = S_IDLE;
          pass_n  = '0;
          gap_n   = '0;
        end else if (gap_q == GW'(GAP_LAST)) begin
          state_n = S_SHIFT;
          gap_n   = '0;
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they land in registers aligned with it.
  assign last_idx_n = IW'(cfg_n.len) + IW'(PAR) - IW'(1);
  assign sel_n      = IW'(cfg_n.len) - IW'(1) - idx_n;

  always_comb begin
    bit_n = 1'b0;
    par_n = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (IW'(i) == sel_n) bit_n = cfg_n.pat[i];
      if (IW'(i) < IW'(cfg_n.len)) par_n = par_n ^ cfg_n.pat[i];
    end
  end

  always_comb begin
    ready_n = (state_n == S_IDLE);
    valid_n = (state_n == S_SHIFT);
    done_n  = (state_n == S_DONE);
    last_n  = valid_n && (idx_n == last_idx_n);
    data_n  = 1'b0;
    if (valid_n) begin
      if ((PAR != 0) && (idx_n == IW'(cfg_n.len))) data_n = par_n;
      else                                         data_n = bit_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      gap_q   <= '0;
      ready_q <= 1'b1;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cfg_q   <= cfg_n;
      idx_q   <= idx_n;
      pass_q  <= pass_n;
      gap_q   <= gap_n;
      ready_q <= ready_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      done_q  <= done_n;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: stimulus pushes time-stamped expected bits and done
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_fsm_seq_gen;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
`ifdef FSM_SEQ_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  fsm_seq_gen_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  fsm_seq_gen #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  typedef struct {
    int   stamp;
    logic data;
    logic last;
  } bit_t;

  bit_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  bit_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.valid_o) begin
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("bit_cycle", cyc, e.stamp);
          check("data", int'(bus.data_o), int'(e.data));
          check("last", int'(bus.last_o), int'(e.last));
        end
      end else if (bus.last_o) begin
        check("last_without_valid", 1, 0);
      end
      if (bus.done_o) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", int'(bus.ready_o), 1);
  endtask

  // Returns #1 after the accept edge, i.e. inside output cycle 1.
  task automatic start_run(input logic [7:0] pat, input logic [3:0] len,
                           input logic [3:0] reps, output int acc);
    wait_ready();
    bus.pattern_i = pat;
    bus.len_i     = len;
    bus.reps_i    = reps;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    bus.start_i = 1'b0;
  endtask

  task automatic push_run(input logic [15:0] bits, input int n, input int passes, input int acc);
    bit_t b;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++) begin
        b.stamp = acc + p * (n + GAP) + k;
        b.data  = bits[n-1-k];
        b.last  = (k == n - 1);
        exp_q.push_back(b);
      end
    done_q.push_back(acc + passes * (n + GAP) - GAP);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size() + done_q.size(), 0);
  endtask

  task automatic check_idle(string name);
    check({name, "_ready"}, int'(bus.ready_o), 1);
    check({name, "_valid"}, int'(bus.valid_o), 0);
    check({name, "_last"},  int'(bus.last_o), 0);
    check({name, "_done"},  int'(bus.done_o), 0);
  endtask

  initial begin
    int acc;
    bit_t b;
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.pattern_i = '0;
    bus.len_i     = '0;
    bus.reps_i    = '0;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_data", int'(bus.data_o), 0);
    reset_i = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;

    // "10", one pass: bits on cycles 1-2(+parity), done next, ready the cycle after.
    start_run(8'h02, 4'd2, 4'd0, acc);
    push_run(PB ? 16'b101 : 16'b10, 2 + PB, 1, acc);
    check("busy_ready", int'(bus.ready_o), 0);
    repeat (3 + PB) @(posedge clk);
    #1;
    check("ready_after_done", int'(bus.ready_o), 1);
    drain();

    // 0xA5 full width, three passes with gaps.
    start_run(8'hA5, 4'd8, 4'd2, acc);
    push_run(PB ? 16'b101001010 : 16'b10100101, 8 + PB, 3, acc);
    drain();

    // len=0 is ignored.
    bus.pattern_i = 8'hFF;
    bus.len_i     = 4'd0;
    bus.start_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    repeat (3) begin
      check_idle("len0");
      @(posedge clk); #1;
    end

    // abort has priority over start in IDLE.
    bus.len_i   = 4'd3;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    @(posedge clk); #1;
    check_idle("abort_idle");

    // len=12 clamps to 8.
    start_run(8'h3C, 4'd12, 4'd0, acc);
    push_run(PB ? 16'b001111000 : 16'b00111100, 8 + PB, 1, acc);
    drain();

    // len=1 with reps all-ones: 16 single-bit passes.
    start_run(8'h01, 4'd1, 4'hF, acc);
    push_run(PB ? 16'b11 : 16'b1, 1 + PB, 16, acc);
    drain();

    // abort during the 3rd SHIFT cycle.
    start_run(8'hFF, 4'd8, 4'd1, acc);
    for (int k = 0; k < 3; k++) begin
      b.stamp = acc + k; b.data = 1'b1; b.last = 1'b0;
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    check_idle("abort");
    drain();

    // synchronous reset during the 4th SHIFT cycle.
    start_run(8'hC3, 4'd8, 4'd0, acc);
    for (int k = 0; k < 4; k++) begin
      b.stamp = acc + k; b.data = (k < 2); b.last = 1'b0;
      exp_q.push_back(b);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    reset_i = 1'b1;
    check_idle("midreset");
    drain();

    // short patterns exercising the parity bit when enabled.
    start_run(8'h06, 4'd3, 4'd0, acc);
    push_run(PB ? 16'b1100 : 16'b110, 3 + PB, 1, acc);
    drain();
    start_run(8'h04, 4'd3, 4'd0, acc);
    push_run(PB ? 16'b1001 : 16'b100, 3 + PB, 1, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
